// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: reset vector, bus widths,
// stall encodings and the output slot record.
package inst_fetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [DATA_W-1:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] INST_BYTES   = 32'h0000_0004;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic              ce;
    } slot_t;

    localparam slot_t SLOT_EMPTY = {ZERO_WORD, ZERO_WORD, 1'b0};

    function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc);
        return pc + INST_BYTES;
    endfunction

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding ROM request, a one-entry output slot
// and a one-entry overflow buffer for a word that returns while the slot is stalled.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic        rom_ack,
    input  logic [31:0] rom_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_rom_ce,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              redir_r, redir_s;
    logic              req_r, req_s;
    slot_t             slot_r, slot_s;
    slot_t             buf_r, buf_s;

    logic              consume_s;
    logic              slot_free_s;
    logic              branch_s;
    logic [ADDR_W-1:0] tgt_s;
    logic [ADDR_W-1:0] flush_pc_s;
    logic [ADDR_W-1:0] ack_next_s;
    logic [ADDR_W-1:0] resume_s;
    logic              unused_stall_s;

    assign consume_s      = (stall[0] == NO_STOP);
    assign slot_free_s    = ~slot_r.ce | consume_s;
    assign branch_s       = branch_flag_i & consume_s;
    assign tgt_s          = align_word(branch_target_address_i);
    assign flush_pc_s     = align_word(new_pc);
    assign unused_stall_s = ^stall[5:1];

    // redir_r marks that pc_r already holds a branch target while the delay slot is still in flight.
    assign ack_next_s = branch_s ? tgt_s : (redir_r ? pc_r : seq_pc(addr_r));
    assign resume_s   = branch_s ? tgt_s : pc_r;

    // Next-state, next-pc, slot and buffer selection.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        addr_s  = addr_r;
        redir_s = redir_r;
        buf_s   = buf_r;
        slot_s  = consume_s ? SLOT_EMPTY : slot_r;
        if (flush) begin
            slot_s  = SLOT_EMPTY;
            buf_s   = SLOT_EMPTY;
            pc_s    = flush_pc_s;
            redir_s = 1'b0;
            if (((state_r == S_REQ) || (state_r == S_DROP)) && !rom_ack) begin
                state_s = S_DROP;
            end else begin
                state_s = S_REQ;
                addr_s  = flush_pc_s;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_s = S_REQ;
                    pc_s    = resume_s;
                    addr_s  = resume_s;
                end
                S_REQ: begin
                    if (rom_ack) begin
                        pc_s    = ack_next_s;
                        redir_s = 1'b0;
                        if (slot_free_s) begin
                            slot_s = {addr_r, rom_rdata, 1'b1};
                            addr_s = ack_next_s;
                        end else begin
                            buf_s   = {addr_r, rom_rdata, 1'b1};
                            state_s = S_FULL;
                        end
                    end else if (branch_s) begin
                        pc_s    = tgt_s;
                        redir_s = 1'b1;
                    end else begin
                        redir_s = redir_r;
                    end
                end
                S_FULL: begin
                    if (consume_s) begin
                        slot_s  = buf_r;
                        buf_s   = SLOT_EMPTY;
                        pc_s    = resume_s;
                        addr_s  = resume_s;
                        state_s = S_REQ;
                    end else begin
                        buf_s = buf_r;
                    end
                end
                S_DROP: begin
                    // The returning word belongs to the pre-flush stream and is discarded.
                    if (rom_ack) begin
                        pc_s    = resume_s;
                        addr_s  = resume_s;
                        state_s = S_REQ;
                    end else if (branch_s) begin
                        pc_s = tgt_s;
                    end else begin
                        pc_s = pc_r;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                    slot_s  = SLOT_EMPTY;
                end
            endcase
        end
        req_s = (state_s == S_REQ) || (state_s == S_DROP);
    end

    // State, pc, request bus and slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_VECTOR;
            addr_r  <= ZERO_WORD;
            redir_r <= 1'b0;
            req_r   <= 1'b0;
            slot_r  <= SLOT_EMPTY;
            buf_r   <= SLOT_EMPTY;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            addr_r  <= addr_s;
            redir_r <= redir_s;
            req_r   <= req_s;
            slot_r  <= slot_s;
            buf_r   <= buf_s;
        end
    end

    assign rom_req     = req_r;
    assign rom_addr    = addr_r;
    assign if_pc       = slot_r.pc;
    assign if_inst     = slot_r.inst;
    assign if_rom_ce   = slot_r.ce;
    assign stallreq_if = (req_r && !slot_r.ce && !rom_ack) ? STOP : NO_STOP;

endmodule
